// File: rtl/pack_bytes_to_word_pkg.sv
// Shared sizing helper for the byte-to-word packer.
package pack_bytes_to_word_pkg;

   function automatic int lane_idx_w(input int bytes_per_word);
      return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
   endfunction

endpackage

// File: rtl/pack_bytes_to_word.sv
// Packs an 8-bit AXI-Stream into little-endian words; tlast flushes short words with tkeep.
// One accumulator stage feeds one output register; m_* come only from the output register.
module pack_bytes_to_word
   import pack_bytes_to_word_pkg::*;
#(
   parameter int BYTES_PER_WORD = 4
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [7:0]                  s_axis_tdata,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic                        s_axis_tlast,
   input  logic                        s_axis_tuser,
   output logic [8*BYTES_PER_WORD-1:0] m_axis_tdata,
   output logic [BYTES_PER_WORD-1:0]   m_axis_tkeep,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tuser,
   output logic                        err_sof_misaligned
);

   localparam int LANE_W = lane_idx_w(BYTES_PER_WORD);
   localparam int WORD_W = 8 * BYTES_PER_WORD;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

   logic [1:0]                rst_sync_q;
   logic                      rst_n_int;
   logic [LANE_W-1:0]         lane_q;
   logic [WORD_W-1:0]         acc_data_q;
   logic [BYTES_PER_WORD-1:0] acc_keep_q;
   logic                      acc_user_q;
   logic [WORD_W-1:0]         acc_data_nxt;
   logic [BYTES_PER_WORD-1:0] acc_keep_nxt;
   logic                      acc_user_nxt;
   logic                      accept;
   logic                      complete;

   // Assert asynchronously, release two clocks after aresetn rises.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];

   // Ready is masked while the internal reset is held so no byte is silently dropped.
   assign s_axis_tready = rst_n_int && (!m_axis_tvalid || m_axis_tready);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign complete      = accept && ((lane_q == LAST_LANE) || s_axis_tlast);

   always_comb begin
      acc_data_nxt = acc_data_q;
      acc_keep_nxt = acc_keep_q;
      acc_user_nxt = acc_user_q | s_axis_tuser;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
         if (lane_q == LANE_W'(k)) begin
            acc_data_nxt[8*k +: 8] = s_axis_tdata;
            acc_keep_nxt[k]        = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         lane_q     <= '0;
         acc_data_q <= '0;
         acc_keep_q <= '0;
         acc_user_q <= 1'b0;
      end else if (accept) begin
         if (complete) begin
            lane_q     <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            acc_user_q <= 1'b0;
         end else begin
            lane_q     <= lane_q + 1'b1;
            acc_data_q <= acc_data_nxt;
            acc_keep_q <= acc_keep_nxt;
            acc_user_q <= acc_user_nxt;
         end
      end
   end

   // A completing byte reloads the output register even while it drains, so no bubble.
   always_ff @(posedge aclk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
      end else if (complete) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= acc_data_nxt;
         m_axis_tkeep  <= acc_keep_nxt;
         m_axis_tlast  <= s_axis_tlast;
         m_axis_tuser  <= acc_user_nxt;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         err_sof_misaligned <= 1'b0;
      end else begin
         err_sof_misaligned <= accept && s_axis_tuser && (lane_q != '0);
      end
   end

endmodule

// File: doc/pack_bytes_to_word.md
Name: pack_bytes_to_word

Overview:
- Downstream neighbour of the 32-to-8-bit output trimmer in the upscaler output path.
- Accepts the 8-bit AXI-Stream pixel/byte stream and packs consecutive bytes into 32-bit words for the S2MM DMA.
- Uses little-endian lane order. Short final words are flushed on tlast and marked with tkeep.
- Carries start-of-frame (tuser) to the word that contains the first byte.

Parameters:
- BYTES_PER_WORD, 4: bytes packed per output word. Output width is 8*BYTES_PER_WORD. Legal values are 2 and 4.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  input byte.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last byte of packet/frame.
- s_axis_tuser  in  1  start of frame; valid on the first byte.
- m_axis_tdata  out  8*BYTES_PER_WORD  packed word; byte k sits in lane k, bits [8k+7:8k].
- m_axis_tkeep  out  BYTES_PER_WORD  lane-valid mask.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  word holds the tlast byte.
- m_axis_tuser  out  1  word holds a tuser byte.
- err_sof_misaligned  out  1  one-cycle pulse when tuser arrives on a lane other than 0.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - lane counter = 0, accumulator data/keep = 0, pending tuser = 0.
  - m_axis_tvalid = 0; m_axis_tdata/tkeep/tlast/tuser = 0.
  - err_sof_misaligned = 0.
- Datapath: accumulator register (data, keep, tuser) plus one output register. m_* are driven only from the output register.
- Input handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready. This is combinational and gives full 1 byte/cycle throughput.
  - A byte is accepted when s_axis_tvalid && s_axis_tready.
- On accept with lane = L:
  - Write the byte to lane L and set keep[L].
  - OR tuser into the pending tuser.
  - If tuser == 1 and L != 0, pulse err_sof_misaligned for the next cycle only. The byte is still packed normally; no realignment is done.
- Word completion occurs when L == BYTES_PER_WORD-1 or tlast == 1:
  - Next cycle, the output register loads {accumulator incl. this byte, keep, tlast, tuser} and m_axis_tvalid = 1.
  - Accumulator keep/data/tuser clear to 0 and the lane counter wraps to 0.
  - Latency from completing byte to m_axis_tvalid is 1 cycle.
- On non-completing accepts the lane counter increments.
- Lanes not written in a tlast-flushed word have tdata = 0 and tkeep = 0.
- Output handshake:
  - While m_axis_tvalid && !m_axis_tready, all m_* hold stable and s_axis_tready = 0.
  - On m_axis_tready with no new word completing, m_axis_tvalid falls next cycle.
  - Completion in the same cycle as drain reloads the output register back-to-back, with no bubble.
- Input backpressure only occurs while the output register is full and stalled. The accumulator never overflows because an accept requires a free (or draining) output slot.
- tlast on lane 0 emits a 1-byte word with tkeep = 0001.
- tlast and tuser on the same byte: both are set on that word.
- Reset mid-packet discards any partial word and any undelivered output word; no flush is performed.
- No internal timeout. A partial word without tlast waits indefinitely.

Decomposition:
- The shared package holds only the lane index width, clog2(BYTES_PER_WORD).
- No sub-module; the block is one accumulator plus one output-register stage in a single module.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 with tlast on 0x44 and m_axis_tready = 1 -> one word 0x44332211, tkeep = 0xF, tlast = 1, valid one cycle after 0x44 is accepted.
- 6 bytes 0x01..0x06 with tlast on 0x06 -> first word 0x04030201, tkeep = F, tlast = 0; second word 0x00000605, tkeep = 3, tlast = 1.
- Continuous 16-byte stream with tvalid held high and m_axis_tready = 1 -> 4 words on cycles 4, 8, 12, 16 after the first accept; s_axis_tready never drops.
- m_axis_tready held low for 5 cycles while a word is pending -> m_* are stable, s_axis_tready = 0, no byte is lost or duplicated after release (scoreboard).
- tuser on byte 0 of a frame -> m_axis_tuser = 1 on the first word only. tuser on the 3rd byte -> err_sof_misaligned pulses once, and that word has tuser = 1.
- aresetn asserted after 2 bytes of a word -> m_axis_tvalid = 0 immediately. The next 4 bytes after release form a clean word with no stale lanes.
